clk_div_ctrl: RTL and testbench

Runtime-programmable clock divider controller. It generates a divided clock `clk_out` from `clk_in`, with a ready/valid configuration port for the divisor. Start and stop are clean: divisor changes and stops only take effect at a period boundary, so `clk_out` never glitches or produces a runt phase. It sits between the host/config logic and the accelerator blocks that consume slow clocks or period ticks.

---
 rtl/clk_div_ctrl_if.sv | 28 ++
 rtl/clk_div_ctrl.sv | 159 +++++++++++++++
 tb/tb_clk_div_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: divisor configuration port of the clock divider controller.
//   cfg_valid : host offers a new divisor on cfg_div
//   cfg_div   : requested divisor (CNT_WIDTH bits)
//   cfg_ready : controller can accept a divisor (no divisor is waiting to be applied)
//   cfg_err   : one-cycle pulse after an accepted divisor below 2 was rejected
// The master modport is the host side; the slave modport is the controller side.
interface clk_div_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 cfg_valid;
  logic [CNT_WIDTH-1:0] cfg_div;
  logic                 cfg_ready;
  logic                 cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock divider with glitch-free start/stop.
//   clk_in  : system clock, all logic on its rising edge
//   rst     : asynchronous active-high reset
//   run_en  : level request, 1 = run, 0 = stop at the end of the current period
//   cfg     : divisor configuration handshake (clk_div_ctrl_if slave)
//   clk_out : divided clock, high floor(D/2) cycles then low for the rest
//   tick    : one-cycle pulse in the cycle a period starts
//   active  : controller is running or finishing its last period
//   cur_div : divisor currently in effect
// A new divisor and a stop request only take effect at a period boundary,
// so clk_out never shows a runt phase.
module clk_div_ctrl #(
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 128
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 run_en,
  clk_div_ctrl_if.slave        cfg,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 active,
  output logic [CNT_WIDTH-1:0] cur_div
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MIN_DIV = CNT_WIDTH'(2);

  logic [1:0]           state_r,   state_s;
  logic [CNT_WIDTH-1:0] cnt_r,     cnt_s;
  logic [CNT_WIDTH-1:0] cur_div_r, cur_div_s;
  logic [CNT_WIDTH-1:0] pend_div_r, pend_div_s;
  logic                 clk_out_r, clk_out_s;
  logic                 tick_r,    tick_s;
  logic                 active_r,  active_s;
  logic                 ready_r,   ready_s;
  logic                 err_r,     err_s;
  logic                 boundary_s;

  // A divisor is waiting whenever ready_r is low, so ready_r doubles as "pending empty".
  // Next-state, period counter, divisor apply and config acceptance.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    cur_div_s  = cur_div_r;
    pend_div_s = pend_div_r;
    clk_out_s  = clk_out_r;
    tick_s     = 1'b0;
    ready_s    = ready_r;
    err_s      = 1'b0;
    boundary_s = (cnt_r == (cur_div_r - CNT_ONE));

    case (state_r)
      ST_IDLE: begin
        cnt_s     = '0;
        clk_out_s = 1'b0;
        // In IDLE a waiting divisor is applied on the very next edge.
        if (!ready_r) begin
          cur_div_s = pend_div_r;
          ready_s   = 1'b1;
        end else begin
          cur_div_s = cur_div_r;
        end
        if (run_en) begin
          // Counter 0 is always in the high phase because every divisor is >= 2.
          state_s   = ST_RUN;
          clk_out_s = 1'b1;
          tick_s    = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN, ST_STOP: begin
        if (boundary_s) begin
          if (!ready_r) begin
            cur_div_s = pend_div_r;
            ready_s   = 1'b1;
          end else begin
            cur_div_s = cur_div_r;
          end
          if ((state_r == ST_STOP) && !run_en) begin
            state_s   = ST_IDLE;
            cnt_s     = '0;
            clk_out_s = 1'b0;
          end else begin
            state_s   = run_en ? ST_RUN : ST_STOP;
            cnt_s     = '0;
            clk_out_s = 1'b1;
            tick_s    = 1'b1;
          end
        end else begin
          // Mid-period: a stop request only changes the state, not the waveform.
          state_s   = run_en ? ST_RUN : ST_STOP;
          cnt_s     = cnt_r + CNT_ONE;
          clk_out_s = (cnt_s < (cur_div_r >> 1));
        end
      end

      default: begin
        state_s   = ST_IDLE;
        cnt_s     = '0;
        clk_out_s = 1'b0;
      end
    endcase

    // Acceptance only happens with nothing pending, so it never races the apply above.
    if (cfg.cfg_valid && ready_r) begin
      if (cfg.cfg_div < MIN_DIV) begin
        err_s = 1'b1;
      end else begin
        pend_div_s = cfg.cfg_div;
        ready_s    = 1'b0;
      end
    end else begin
      err_s = 1'b0;
    end

    active_s = (state_s != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      cur_div_r  <= DEF_DIV;
      pend_div_r <= '0;
      clk_out_r  <= 1'b0;
      tick_r     <= 1'b0;
      active_r   <= 1'b0;
      ready_r    <= 1'b1;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cur_div_r  <= cur_div_s;
      pend_div_r <= pend_div_s;
      clk_out_r  <= clk_out_s;
      tick_r     <= tick_s;
      active_r   <= active_s;
      ready_r    <= ready_s;
      err_r      <= err_s;
    end
  end

  assign clk_out       = clk_out_r;
  assign tick          = tick_r;
  assign active        = active_r;
  assign cur_div       = cur_div_r;
  assign cfg.cfg_ready = ready_r;
  assign cfg.cfg_err   = err_r;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed and randomized stimulus for clk_div_ctrl, every
// cycle compared against a period/position reference model with a queue
// holding the waiting divisor.
module tb_clk_div_ctrl;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        run_en;
  logic        clk_out;
  logic        tick;
  logic        active;
  logic [15:0] cur_div;

  clk_div_ctrl_if #(.CNT_WIDTH(16)) cfg_if ();

  clk_div_ctrl #(.CNT_WIDTH(16), .DEFAULT_DIV(128)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .run_en  (run_en),
    .cfg     (cfg_if.slave),
    .clk_out (clk_out),
    .tick    (tick),
    .active  (active),
    .cur_div (cur_div)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // reference model: position within the current period and its length
  int m_div;
  int m_pos;
  bit m_active;
  bit m_stopping;
  bit m_tick;
  bit m_err;
  int pend_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div      = 128;
    m_pos      = 0;
    m_active   = 1'b0;
    m_stopping = 1'b0;
    m_tick     = 1'b0;
    m_err      = 1'b0;
    pend_q.delete();
  endtask

  task automatic model_edge();
    bit acc;
    acc    = cfg_if.cfg_valid && (pend_q.size() == 0);
    m_tick = 1'b0;
    m_err  = 1'b0;
    if (!m_active) begin
      if (pend_q.size() > 0) m_div = pend_q.pop_front();
      m_pos = 0;
      if (run_en) begin
        m_active   = 1'b1;
        m_stopping = 1'b0;
        m_tick     = 1'b1;
      end
    end else if (m_pos == m_div - 1) begin
      if (pend_q.size() > 0) m_div = pend_q.pop_front();
      m_pos = 0;
      if (m_stopping && !run_en) begin
        m_active = 1'b0;
      end else begin
        m_tick     = 1'b1;
        m_stopping = !run_en;
      end
    end else begin
      m_pos++;
      m_stopping = !run_en;
    end
    if (acc) begin
      if (cfg_if.cfg_div < 16'd2) m_err = 1'b1;
      else pend_q.push_back(int'(cfg_if.cfg_div));
    end
  endtask

  task automatic compare_all();
    check("clk_out",   32'(clk_out),          32'(m_active && (m_pos < m_div / 2)));
    check("tick",      32'(tick),             32'(m_tick));
    check("active",    32'(active),           32'(m_active));
    check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(pend_q.size() == 0));
    check("cfg_err",   32'(cfg_if.cfg_err),   32'(m_err));
    check("cur_div",   32'(cur_div),          32'(m_div));
  endtask

  task automatic step();
    @(posedge clk_in);
    if (!rst) model_edge();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_cfg(input int d);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = 16'(d);
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  // wait until the model sits at position p of a period of length d
  task automatic wait_pos(input int d, input int p);
    int budget;
    budget = 600;
    while (!(m_active && m_div == d && m_pos == p) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_pos: timed out waiting for div %0d pos %0d at %0t", d, p, $time);
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 600;
    while (m_active && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: timed out at %0t", $time);
    end
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    steps(2);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    run_en           = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = 16'd0;
    model_reset();
    #1;
    compare_all();
    steps(2);
    rst = 1'b0;
    steps(3);

    // default divisor, reset mid-run, then default waveform again
    run_en = 1'b1;
    steps(50);
    async_reset();
    steps(300);

    // even and odd divisors configured in IDLE
    run_en = 1'b0;
    wait_idle();
    send_cfg(4);
    steps(2);
    run_en = 1'b1;
    steps(20);
    run_en = 1'b0;
    wait_idle();
    send_cfg(5);
    run_en = 1'b1;
    steps(20);
    run_en = 1'b0;
    wait_idle();
    send_cfg(2);
    run_en = 1'b1;
    steps(10);

    // mid-period reconfig 4 -> 6 at counter 1
    send_cfg(4);
    wait_pos(4, 1);
    send_cfg(6);
    steps(20);

    // illegal divisors while running
    send_cfg(1);
    steps(3);
    send_cfg(0);
    steps(8);

    // clean stop at D=8, then stop aborted by raising run_en again
    send_cfg(8);
    wait_pos(8, 2);
    run_en = 1'b0;
    steps(20);
    run_en = 1'b1;
    wait_pos(8, 2);
    run_en = 1'b0;
    wait_pos(8, 5);
    run_en = 1'b1;
    steps(20);

    // transfer on the boundary edge of a D=4 period
    send_cfg(4);
    wait_pos(4, 3);
    send_cfg(10);
    steps(30);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) run_en = ~run_en;
      if ($urandom_range(0, 999) == 0) begin
        async_reset();
      end else if ($urandom_range(0, 7) == 0) begin
        send_cfg(int'($urandom_range(0, 12)));
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
